// File: rtl/regfile_scoreboard.sv
// Integer register file with two async read ports, one sync write port, write-to-read bypass and per-register pending-write counters.
// Latency: reads/BUSY/ISSUE_READY are combinational (0 cycles); writes and counter updates land on the next CLK rising edge.
// Backpressure: ISSUE_READY drops when a destination's counter is saturated; the issuer holds ISSUE and retries.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    parameter int PCNT_W = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            BUSY1,
    output logic            BUSY2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            EN,
    input  logic            ISSUE,
    input  logic [AW-1:0]   ISSUE_RD,
    output logic            ISSUE_READY,
    output logic            ERR
);

    localparam logic [PCNT_W-1:0] PCNT_MAX = '1;
    localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);
    localparam logic              BYP      = (BYPASS != 0);

    logic [XLEN-1:0]   regs [NREG];
    logic [PCNT_W-1:0] pcnt [NREG];
    logic              err_q;

    logic              wr_any;
    logic              issue_rdy_raw;
    logic              issue_acc;
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;

    assign wr_any = EN && (A3 != '0);

    // Read port 1: x0 reads zero, optional bypass of the write in flight, else array; forced low during reset.
    always_comb begin
        RD1 = '0;
        if (RST_N && A1 != '0) begin
            if (BYP && EN && A3 == A1) RD1 = WD3;
            else                       RD1 = regs[A1];
        end
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        RD2 = '0;
        if (RST_N && A2 != '0) begin
            if (BYP && EN && A3 == A2) RD2 = WD3;
            else                       RD2 = regs[A2];
        end
    end

    // Hazard flag for port 1: pending writes outstanding, unless the last one is being bypassed right now.
    always_comb begin
        BUSY1 = 1'b0;
        if (RST_N && A1 != '0 && pcnt[A1] != '0) begin
            BUSY1 = 1'b1;
            if (BYP && EN && A3 == A1 && pcnt[A1] == PCNT_ONE) BUSY1 = 1'b0;
        end
    end

    // Hazard flag for port 2: same rule as port 1.
    always_comb begin
        BUSY2 = 1'b0;
        if (RST_N && A2 != '0 && pcnt[A2] != '0) begin
            BUSY2 = 1'b1;
            if (BYP && EN && A3 == A2 && pcnt[A2] == PCNT_ONE) BUSY2 = 1'b0;
        end
    end

    // Reservation acceptance: free slot, or a same-cycle writeback releases one.
    always_comb begin
        issue_rdy_raw = 1'b1;
        if (ISSUE_RD != '0) begin
            issue_rdy_raw = (pcnt[ISSUE_RD] != PCNT_MAX) ||
                            (EN && A3 == ISSUE_RD && pcnt[ISSUE_RD] != '0);
        end
    end

    assign ISSUE_READY = RST_N && issue_rdy_raw;
    assign issue_acc   = ISSUE && issue_rdy_raw && (ISSUE_RD != '0);
    assign ERR         = RST_N && err_q;

    // Per-register increment/decrement requests; x0 is never tracked.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = issue_acc && (ISSUE_RD == AW'(r));
            dec_vec[r] = EN && (A3 == AW'(r)) && (pcnt[r] != '0);
        end
    end

    // State update: array write, counter inc/dec, sticky error on untracked writeback.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                pcnt[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wr_any) regs[A3] <= WD3;
            for (int r = 1; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r])      pcnt[r] <= pcnt[r] + PCNT_ONE;
                else if (dec_vec[r] && !inc_vec[r]) pcnt[r] <= pcnt[r] - PCNT_ONE;
            end
            if (wr_any && pcnt[A3] == '0) err_q <= 1'b1;
        end
    end

endmodule
